mem_cache_ctrl: RTL and testbench

MEM_CACHE_CTRL -- requirements
Module: mem_cache_ctrl

---
 rtl/risc_cache_pkg.sv | 28 ++
 rtl/mem_word_seq.sv | 55 +++++
 rtl/mem_cache_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_cache_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_cache_pkg.sv
// risc_cache_pkg: shared types and address-field helpers for the MEM-stage cache controller.
package risc_cache_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int DEF_INDEX_W = 5;
    localparam int DEF_WORDS   = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WBACK  = 3'd2,
        ST_FILL   = 3'd3,
        ST_RESP   = 3'd4,
        ST_ERR    = 3'd5
    } cache_state_t;

    // Width of the word-offset field for a line of 'words' 16-bit words.
    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    // Tag width left over once index, word offset and byte bit are removed.
    function automatic int tag_w(input int index_w, input int words);
        return ADDR_W - index_w - $clog2(words) - 1;
    endfunction

endpackage

// File: rtl/mem_word_seq.sv
// mem_word_seq: walks the words of one cache line against the backing memory.
// Holds the request high across words and only advances on m_ack.
module mem_word_seq
    import risc_cache_pkg::*;
#(
    parameter int WORDS = DEF_WORDS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     m_ack,
    output logic                     busy,
    output logic [off_w(WORDS)-1:0]  word,
    output logic                     last_ack
);

    localparam int OFF_W = off_w(WORDS);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    logic             busy_q, busy_d;
    logic [OFF_W-1:0] word_q, word_d;

    // Next word/busy: a start restarts the line even while the previous one finishes.
    always_comb begin
        busy_d = busy_q;
        word_d = word_q;
        if (start) begin
            busy_d = 1'b1;
            word_d = '0;
        end else if (busy_q && m_ack) begin
            if (word_q == LAST_WORD) begin
                busy_d = 1'b0;
                word_d = '0;
            end else begin
                word_d = word_q + 1'b1;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            word_q <= '0;
        end else begin
            busy_q <= busy_d;
            word_q <= word_d;
        end
    end

    assign busy     = busy_q;
    assign word     = word_q;
    assign last_ack = busy_q & m_ack & (word_q == LAST_WORD);

endmodule

// File: rtl/mem_cache_ctrl.sv
// mem_cache_ctrl: direct-mapped, write-back, write-allocate cache controller
// for the MEM stage. The tag/data array lives outside; this block drives it.
// Build option: define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module mem_cache_ctrl
    import risc_cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int WORDS   = DEF_WORDS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    input  logic                             req_wr,
    input  logic [ADDR_W-1:0]                req_addr,
    input  logic [DATA_W-1:0]                req_wdata,
    output logic                             req_ready,
    output logic                             stall,
    output logic                             rsp_valid,
    output logic [DATA_W-1:0]                rsp_rdata,
    output logic                             rsp_err,
    output logic [INDEX_W-1:0]               c_index,
    output logic [off_w(WORDS)-1:0]          c_offset,
    output logic [tag_w(INDEX_W, WORDS)-1:0] c_tag,
    output logic [DATA_W-1:0]                c_wdata,
    output logic                             c_we,
    output logic                             c_set_valid,
    output logic                             c_set_dirty,
    input  logic                             c_hit,
    input  logic                             c_dirty,
    input  logic [tag_w(INDEX_W, WORDS)-1:0] c_tag_out,
    input  logic [DATA_W-1:0]                c_rdata,
    output logic                             m_req,
    output logic                             m_wr,
    output logic [ADDR_W-1:0]                m_addr,
    output logic [DATA_W-1:0]                m_wdata,
    input  logic                             m_ack,
    input  logic [DATA_W-1:0]                m_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]                      hit_cnt,
    output logic [15:0]                      miss_cnt
`endif
);

    localparam int OFF_W = off_w(WORDS);
    localparam int TAG_W = tag_w(INDEX_W, WORDS);

    cache_state_t      state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:1] addr_q, addr_d;     // byte bit is never needed after acceptance
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              seq_start;
    logic              seq_busy;
    logic              seq_last_ack;
    logic [OFF_W-1:0]  seq_word;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [OFF_W-1:0]   req_off;

    assign req_tag = addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx = addr_q[OFF_W+1 +: INDEX_W];
    assign req_off = addr_q[1 +: OFF_W];

    mem_word_seq #(
        .WORDS    (WORDS)
    ) u_word_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (seq_start),
        .m_ack    (m_ack),
        .busy     (seq_busy),
        .word     (seq_word),
        .last_ack (seq_last_ack)
    );

    // Next-state and request-latch logic; a miss always returns to LOOKUP so the
    // access completes through the ordinary hit path.
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        seq_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr[ADDR_W-1:1];
                    wdata_d = req_wdata;
                    state_d = req_addr[0] ? ST_ERR : ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (c_hit) begin
                    if (!wr_q) begin
                        rdata_d = c_rdata;
                    end
                    state_d = ST_RESP;
                end else begin
                    seq_start = 1'b1;
                    state_d   = c_dirty ? ST_WBACK : ST_FILL;
                end
            end
            ST_WBACK: begin
                if (seq_last_ack) begin
                    seq_start = 1'b1;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (seq_last_ack) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state and latched request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Array and memory drive decoded from the registered state; the write-back
    // address is rebuilt from the tag still stored in the victim line.
    always_comb begin
        c_offset    = req_off;
        c_we        = 1'b0;
        c_set_dirty = 1'b0;
        c_set_valid = 1'b0;
        c_wdata     = '0;
        m_wr        = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;
        case (state_q)
            ST_LOOKUP: begin
                if (c_hit && wr_q) begin
                    c_we        = 1'b1;
                    c_set_dirty = 1'b1;
                    c_wdata     = wdata_q;
                end
            end
            ST_WBACK: begin
                c_offset = seq_word;
                m_wr     = 1'b1;
                m_addr   = {c_tag_out, req_idx, seq_word, 1'b0};
                m_wdata  = c_rdata;
            end
            ST_FILL: begin
                c_offset    = seq_word;
                m_addr      = {req_tag, req_idx, seq_word, 1'b0};
                c_we        = seq_busy & m_ack;
                c_wdata     = m_rdata;
                c_set_valid = seq_last_ack;
            end
            default: ;
        endcase
    end

    assign c_index   = req_idx;
    assign c_tag     = req_tag;
    assign m_req     = seq_busy;
    assign req_ready = (state_q == ST_IDLE);
    assign stall     = (state_q != ST_IDLE) | (req_valid & (state_q == ST_IDLE));
    assign rsp_valid = (state_q == ST_RESP) | (state_q == ST_ERR);
    assign rsp_err   = (state_q == ST_ERR);
    assign rsp_rdata = (state_q == ST_RESP && !wr_q) ? rdata_q : '0;

`ifdef CACHE_STATS_EN
    logic        replay_q, replay_d;
    logic        first_lookup;
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Count only the first LOOKUP of a request; the post-fill replay is not a new access.
    always_comb begin
        replay_d = replay_q;
        if (state_q == ST_IDLE && req_valid) begin
            replay_d = 1'b0;
        end else if (state_q == ST_FILL && seq_last_ack) begin
            replay_d = 1'b1;
        end
        first_lookup = (state_q == ST_LOOKUP) && !replay_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (first_lookup && c_hit && hit_cnt_q != 16'hFFFF) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
        if (first_lookup && !c_hit && miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            replay_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            replay_q   <= replay_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// tb_mem_cache_ctrl: scoreboard bench with a behavioural cache array, a
// backing memory with random ack delay and an architectural memory image.
module tb_mem_cache_ctrl;

    localparam int LINES = 32;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready, stall, rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic [4:0]  c_index;
    logic [1:0]  c_offset;
    logic [7:0]  c_tag, c_tag_out;
    logic [15:0] c_wdata, c_rdata;
    logic        c_we, c_set_valid, c_set_dirty, c_hit, c_dirty;
    logic        m_req, m_wr;
    logic [15:0] m_addr, m_wdata;
    logic        m_ack = 1'b0;
    logic [15:0] m_rdata = '0;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    mem_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .stall(stall),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .c_index(c_index), .c_offset(c_offset), .c_tag(c_tag), .c_wdata(c_wdata),
        .c_we(c_we), .c_set_valid(c_set_valid), .c_set_dirty(c_set_dirty),
        .c_hit(c_hit), .c_dirty(c_dirty), .c_tag_out(c_tag_out), .c_rdata(c_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] init_val(input int w);
        return 16'(w * 40503) ^ 16'h5A5A;
    endfunction

    // ---------------- cache array model ----------------
    logic        v_m [LINES] = '{default: 1'b0};
    logic [7:0]  t_m [LINES] = '{default: 8'h00};
    logic        d_m [LINES] = '{default: 1'b0};
    logic [15:0] w_m [LINES][WORDS] = '{default: '{default: 16'h0000}};

    assign c_hit     = v_m[c_index] && (t_m[c_index] == c_tag);
    assign c_dirty   = d_m[c_index];
    assign c_tag_out = t_m[c_index];
    assign c_rdata   = w_m[c_index][c_offset];

    always @(posedge clk) begin
        if (c_we) begin
            w_m[c_index][c_offset] <= c_wdata;
            d_m[c_index]           <= c_set_dirty;
        end
        if (c_set_valid) begin
            v_m[c_index] <= 1'b1;
            t_m[c_index] <= c_tag;
        end
    end

    // ---------------- backing memory + op scoreboard ----------------
    typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; } mop_t;
    mop_t mop_q[$];
    logic [15:0] mem [32768];
    bit mem_ready = 0;
    bit serving = 0;
    int wait_left = 0;
    int fixed_delay = -1;
    int ack_total = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ack <= 1'b0;
            serving = 0;
            if (!mem_ready) begin
                for (int i = 0; i < 32768; i++) mem[i] = init_val(i);
                mem_ready = 1;
            end
        end else begin
            m_ack <= 1'b0;
            if (m_req && !m_ack) begin
                if (!serving) begin
                    serving = 1;
                    wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                end
                if (wait_left == 0) begin
                    mop_t e;
                    checks++;
                    if (mop_q.size() == 0) begin
                        failures++;
                        $display("FAIL mem_op unexpected: got wr=%0d addr=%h", m_wr, m_addr);
                    end else begin
                        e = mop_q.pop_front();
                        if (m_wr !== e.wr || m_addr !== e.addr || (e.wr && m_wdata !== e.data)) begin
                            failures++;
                            $display("FAIL mem_op: got wr=%0d addr=%h data=%h, want wr=%0d addr=%h data=%h",
                                     m_wr, m_addr, m_wdata, e.wr, e.addr, e.data);
                        end
                    end
                    if (m_wr) mem[m_addr[15:1]] = m_wdata;
                    m_rdata <= mem[m_addr[15:1]];
                    m_ack   <= 1'b1;
                    ack_total++;
                    serving = 0;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Memory request must hold address/data stable until acknowledged.
    bit          pend = 0;
    logic        hold_wr;
    logic [15:0] hold_addr, hold_data;
    always @(negedge clk) begin
        if (!rst_n || !m_req) begin
            pend = 0;
        end else begin
            if (pend) begin
                checks++;
                if (m_wr !== hold_wr || m_addr !== hold_addr || m_wdata !== hold_data) begin
                    failures++;
                    $display("FAIL m_hold: got wr=%0d addr=%h data=%h, want wr=%0d addr=%h data=%h",
                             m_wr, m_addr, m_wdata, hold_wr, hold_addr, hold_data);
                end
            end else begin
                pend = 1;
                hold_wr = m_wr; hold_addr = m_addr; hold_data = m_wdata;
            end
            if (m_ack) pend = 0;
        end
    end

    // ---------------- response scoreboard ----------------
    typedef struct { logic [15:0] rdata; bit err; int lat; } rsp_t;
    rsp_t rsp_q[$];
    int accept_cyc = 0;
    bit cur_err = 0;
    bit cur_nomem = 0;

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            rsp_t e;
            checks++;
            if (rsp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp unexpected: got rdata=%h err=%0d", rsp_rdata, rsp_err);
            end else begin
                e = rsp_q.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                    failures++;
                    $display("FAIL rsp: got rdata=%h err=%0d, want rdata=%h err=%0d",
                             rsp_rdata, rsp_err, e.rdata, e.err);
                end
                if (e.lat >= 0) begin
                    checks++;
                    if (cyc - accept_cyc != e.lat) begin
                        failures++;
                        $display("FAIL rsp_latency: got %0d, want %0d", cyc - accept_cyc, e.lat);
                    end
                end
            end
        end
        if (rst_n && cur_nomem) begin
            checks++;
            if (m_req !== 1'b0 || (cur_err && (c_we !== 1'b0 || c_set_valid !== 1'b0))) begin
                failures++;
                $display("FAIL no_side_effect: got m_req=%0d c_we=%0d c_set_valid=%0d, want 0",
                         m_req, c_we, c_set_valid);
            end
        end
    end

    // ---------------- reference model (architectural view) ----------------
    logic [15:0] ref_mem [32768];
    bit          touched [32768];
    bit          dv [LINES];
    logic [7:0]  dt [LINES];
    bit          dd [LINES];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic do_req(input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
        rsp_t r;
        mop_t m;
        logic [4:0] idx;
        logic [7:0] tg;
        bit done;
        bit stall_ok;
        int n;
        idx = addr[7:3];
        tg  = addr[15:8];
        r.rdata = '0;
        r.err = 0;
        r.lat = -1;
        if (addr[0]) begin
            r.err = 1;
            r.lat = 1;
        end else begin
            for (int w = 0; w < WORDS; w++) touched[{tg, idx, 2'(w)}] = 1;
            if (dv[idx] && dt[idx] == tg) begin
                r.lat = 2;
            end else begin
                if (dv[idx] && dd[idx]) begin
                    for (int w = 0; w < WORDS; w++) begin
                        m.wr = 1; m.addr = {dt[idx], idx, 2'(w), 1'b0};
                        m.data = ref_mem[m.addr[15:1]];
                        mop_q.push_back(m);
                    end
                end
                for (int w = 0; w < WORDS; w++) begin
                    m.wr = 0; m.addr = {tg, idx, 2'(w), 1'b0}; m.data = '0;
                    mop_q.push_back(m);
                end
                dv[idx] = 1; dt[idx] = tg; dd[idx] = 0;
            end
            if (wr) begin
                ref_mem[addr[15:1]] = wdata;
                dd[idx] = 1;
            end else begin
                r.rdata = ref_mem[addr[15:1]];
            end
        end
        rsp_q.push_back(r);

        @(negedge clk);
        chk("req_ready_idle", 16'(req_ready), 16'h1);
        req_valid = 1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        accept_cyc = cyc;
        cur_err = addr[0];
        cur_nomem = (r.lat >= 0);
        @(posedge clk);
        #1 req_valid = 0;
        done = 0; stall_ok = 1; n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin
                done = 1;
                req_valid = 0;
            end else begin
                if (stall !== 1'b1 || req_ready !== 1'b0) stall_ok = 0;
                req_valid = ($urandom_range(0, 1) == 1);
                req_wr = ($urandom_range(0, 1) == 1);
                req_addr = 16'($urandom);
                req_wdata = 16'($urandom);
            end
        end
        chk("rsp_arrived", 16'(done), 16'h1);
        chk("stall_busy", 16'(stall_ok), 16'h1);
        @(posedge clk);
        cur_err = 0;
        cur_nomem = 0;
        chk("mem_ops_left", 16'(mop_q.size()), 16'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] tags [4];
        logic [15:0] a;
        logic [15:0] act;
        int n;
        int a0;
        tags[0] = 8'h01; tags[1] = 8'h22; tags[2] = 8'h32; tags[3] = 8'h4C;
        for (int i = 0; i < 32768; i++) begin
            ref_mem[i] = init_val(i);
            touched[i] = 0;
        end
        for (int i = 0; i < LINES; i++) begin
            dv[i] = 0; dt[i] = '0; dd[i] = 0;
        end

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 16'(req_ready), 16'h1);
        chk("rst_stall", 16'(stall), 16'h0);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rst_m_req", 16'(m_req), 16'h0);
        chk("rst_c_we", 16'(c_we), 16'h0);
        rst_n = 1;
        @(negedge clk);
        chk("idle_req_ready", 16'(req_ready), 16'h1);
        chk("idle_m_req", 16'(m_req), 16'h0);

        // Directed: clean load miss, then a load hit to the same word.
        do_req(0, 16'h0104, 16'h0000);
        do_req(0, 16'h0104, 16'h0000);
        // Store to a clean miss, then a dirty-line load miss with slow acks.
        do_req(1, 16'h2208, 16'hBEEF);
        fixed_delay = 5;
        do_req(0, 16'h3208, 16'h0000);
        fixed_delay = -1;
        do_req(0, 16'h2208, 16'h0000);
        // Unaligned access.
        do_req(0, 16'h0011, 16'h0000);

        // Random traffic over a few conflicting tags.
        for (int t = 0; t < 200; t++) begin
            a = {tags[$urandom_range(0, 3)], 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0)};
            do_req($urandom_range(0, 1) == 1, a, 16'($urandom));
        end

        // Reset during the second word of a fill (line 31 is never used elsewhere).
        fixed_delay = 2;
        for (int w = 0; w < WORDS; w++) begin
            mop_t m;
            m.wr = 0; m.addr = {8'h77, 5'd31, 2'(w), 1'b0}; m.data = '0;
            mop_q.push_back(m);
        end
        a0 = ack_total;
        @(negedge clk);
        req_valid = 1; req_wr = 0; req_addr = 16'h77F8;
        @(posedge clk);
        #1 req_valid = 0;
        n = 0;
        while (ack_total == a0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("first_fill_ack", 16'(ack_total - a0), 16'h1);
        @(negedge clk);
        chk("second_word_pending", 16'(m_req), 16'h1);
        rst_n = 0;
        #1;
        chk("abort_m_req", 16'(m_req), 16'h0);
        chk("abort_req_ready", 16'(req_ready), 16'h1);
        chk("abort_stall", 16'(stall), 16'h0);
        chk("abort_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("abort_c_we", 16'(c_we), 16'h0);
        chk("abort_m_addr", m_addr, 16'h0000);
`ifdef CACHE_STATS_EN
        chk("abort_hit_cnt", hit_cnt, 16'h0000);
        chk("abort_miss_cnt", miss_cnt, 16'h0000);
`endif
        mop_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        fixed_delay = -1;
        @(negedge clk);
        chk("post_reset_m_req", 16'(m_req), 16'h0);

        for (int t = 0; t < 20; t++) begin
            a = {tags[$urandom_range(0, 3)], 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b0};
            do_req($urandom_range(0, 1) == 1, a, 16'($urandom));
        end
        chk("rsp_queue_empty", 16'(rsp_q.size()), 16'h0);

        // Cache + memory together must equal the architectural image.
        for (int w = 0; w < 32768; w++) begin
            if (touched[w]) begin
                logic [14:0] wa;
                wa = 15'(w);
                if (v_m[wa[6:2]] && t_m[wa[6:2]] == wa[14:7]) act = w_m[wa[6:2]][wa[1:0]];
                else act = mem[w];
                checks++;
                if (act !== ref_mem[w]) begin
                    failures++;
                    $display("FAIL coherency word %h: got %h, want %h", wa, act, ref_mem[w]);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
